// File: rtl/disp_pkg.sv
// Shared constants and types for seven-segment display paths.
//   NUM_DIGITS / NIBBLE_W / DATA_W : digit count and value widths
//   SEG_W, AN_W                    : segment and anode bus widths
//   SEG_OFF, AN_OFF                : idle (all dark) bus values, active-low
//   HEX_SEG                        : nibble -> active-low a..g pattern, dp off
//   scan_out_t                     : registered segment + anode payload
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned AN_W       = NUM_DIGITS;
    localparam int unsigned PWM_W      = 4;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;
    localparam logic [AN_W-1:0]  AN_OFF  = 4'hF;

    // Element [n] is the pattern for nibble n; bit7 (dp) is high (off).
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    typedef struct packed {
        logic [SEG_W-1:0] seg_n;
        logic [AN_W-1:0]  an_n;
    } scan_out_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble_i : value 0..F to show
//   dp_i     : 1 lights the decimal point (clears bit7)
//   seg_n_c  : active-low segments, bit0=a .. bit6=g, bit7=dp
module hex7seg_decode
    import disp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    input  logic                dp_i,
    output logic [SEG_W-1:0]    seg_n_c
);

    always_comb begin
        seg_n_c = HEX_SEG[nibble_i];
        if (dp_i) begin
            seg_n_c[SEG_W-1] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver.
// Captures a 16-bit value into a shadow register, transfers it to the
// display register only at frame boundaries (tear-free), and scans one
// digit per slot with dead time, leading-zero blanking and 16-level PWM.
//   clk, rst    : single clock, asynchronous active-high reset
//   data, load  : value and capture strobe (data[3:0] is digit 0)
//   lz_blank    : leading-zero blanking enable (live)
//   dp          : per-digit decimal point enables (live)
//   bright      : brightness, lit fraction (bright+1)/16 of active window
//   seg_n, an_n : registered active-low segment / anode buses
//   frame_tick  : one-cycle pulse on the last output cycle of slot 3
// CLK_DIV must be at least BLANK_CYCLES+2.
module seg_scan_driver
    import disp_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              lz_blank,
    input  logic [AN_W-1:0]   dp,
    input  logic [PWM_W-1:0]  bright,
    output logic [SEG_W-1:0]  seg_n,
    output logic [AN_W-1:0]   an_n,
    output logic              frame_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DIG_W-1:0]  dig_q,    dig_d;
    logic [PWM_W-1:0]  pwm_q,    pwm_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] disp_q,   disp_d;
    scan_out_t         out_q,    out_d;
    logic              tick_q,   tick_d;

    logic                slot_end;
    logic                frame_wrap;
    logic [AN_W-1:0]     lz_mask;
    logic                zero_run;
    logic [NIBBLE_W-1:0] cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [AN_W-1:0]     an_sel;
    logic                lit;
    logic [SEG_W-1:0]    seg_dec;

    // Slot/digit/PWM counters and the tear-free shadow -> display transfer.
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = slot_end && (dig_q == DIG_LAST);
        cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
        dig_d      = slot_end ? dig_q + DIG_W'(1) : dig_q;
        pwm_d      = pwm_q + PWM_W'(1);
        shadow_d   = load ? data : shadow_q;
        // Using shadow_d lets a load on the boundary cycle go straight through.
        disp_d     = frame_wrap ? shadow_d : disp_q;
    end

    // Digit k>0 is blanked when it and every more-significant nibble are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (disp_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz_mask[i] = lz_blank && zero_run;
        end
    end

    // Select the nibble, dp and blank flag of the digit in the current slot.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q == DIG_W'(i)) begin
                cur_nib   = disp_q[i*NIBBLE_W +: NIBBLE_W];
                cur_dp    = dp[i];
                cur_blank = lz_mask[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    hex7seg_decode u_decode (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .seg_n_c  (seg_dec)
    );

    // Anodes and segments are registered from the same lit decision,
    // so a new anode never appears with the previous digit's segments.
    always_comb begin
        lit         = (cnt_q >= CNT_BLANK) && (pwm_q <= bright) && !cur_blank;
        out_d.seg_n = lit ? seg_dec : SEG_OFF;
        out_d.an_n  = lit ? an_sel  : AN_OFF;
        tick_d      = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            dig_q       <= '0;
            pwm_q       <= '0;
            shadow_q    <= '0;
            disp_q      <= '0;
            out_q.seg_n <= SEG_OFF;
            out_q.an_n  <= AN_OFF;
            tick_q      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            pwm_q    <= pwm_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign seg_n      = out_q.seg_n;
    assign an_n       = out_q.an_n;
    assign frame_tick = tick_q;

endmodule
